// File: rtl/plic_gateway_bank.sv
// Per-source PLIC interrupt gateways: each raw line becomes one pending bit that
// stays held until the hart claims it, and the source stays blocked until the hart completes it.
module plic_gateway_bank #(
  parameter int unsigned     NSRC      = 4,
  parameter int unsigned     IDW       = 3,
  parameter logic [NSRC-1:0] EDGE_MASK = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] io_src,
  input  logic            io_claim_valid,
  input  logic [IDW-1:0]  io_claim_id,
  input  logic            io_complete_valid,
  input  logic [IDW-1:0]  io_complete_id,
  output logic [NSRC-1:0] io_ip,
  output logic [NSRC-1:0] io_inflight,
  output logic [NSRC-1:0] io_drop
);

  localparam int unsigned CNTW = 2;
  localparam int unsigned TOKW = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND     = 2'd1,
    INFLIGHT = 2'd2
  } state_e;

  // The edge counter holds at most 3 queued edges.
  function automatic logic [CNTW-1:0] sat_cnt(input logic [TOKW-1:0] t);
    return (t > TOKW'(3)) ? CNTW'(3) : t[CNTW-1:0];
  endfunction

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    localparam logic [IDW-1:0] SRC_ID  = IDW'(i + 1);
    localparam bit             IS_EDGE = EDGE_MASK[i];

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [TOKW-1:0] tokens;
    logic            prev_q;
    logic            rise;
    logic            req;
    logic            claim_hit;
    logic            complete_hit;
    logic            drop_d;
    logic            ip_q, inflight_q, drop_q;

    // IDs 0 and > NSRC never match any SRC_ID, so they are ignored for free.
    assign claim_hit    = io_claim_valid && (io_claim_id == SRC_ID);
    assign complete_hit = io_complete_valid && (io_complete_id == SRC_ID);
    assign rise         = IS_EDGE && io_src[i] && !prev_q;
    assign tokens       = TOKW'(cnt_q) + TOKW'(rise);
    assign req          = IS_EDGE ? (tokens != '0) : io_src[i];

    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      drop_d  = IS_EDGE && (tokens == TOKW'(4));
      case (state_q)
        IDLE:     if (req)          state_d = PEND;
        PEND:     if (claim_hit)    state_d = INFLIGHT;
        INFLIGHT: if (complete_hit) state_d = IDLE;
        default:                    state_d = IDLE;
      endcase
      // One queued edge is consumed when an idle gateway goes pending.
      if (IS_EDGE) begin
        if ((state_q == IDLE) && (tokens != '0)) cnt_d = sat_cnt(TOKW'(tokens - TOKW'(1)));
        else                                     cnt_d = sat_cnt(tokens);
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        prev_q     <= 1'b0;
        ip_q       <= 1'b0;
        inflight_q <= 1'b0;
        drop_q     <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        prev_q     <= io_src[i];
        ip_q       <= (state_d == PEND);
        inflight_q <= (state_d == INFLIGHT);
        drop_q     <= drop_d;
      end
    end

    assign io_ip[i]       = ip_q;
    assign io_inflight[i] = inflight_q;
    assign io_drop[i]     = drop_q;
  end

endmodule

// File: tb/tb_plic_gateway_bank.sv
// Bench for plic_gateway_bank: directed test-plan steps followed by random traffic,
// all compared against a per-source behavioural model.
module tb_plic_gateway_bank;

  localparam int unsigned NSRC = 4;
  localparam int unsigned IDW  = 3;
  localparam logic [NSRC-1:0] EMASK = 4'b0010;

  logic            clock;
  logic            reset;
  logic [NSRC-1:0] io_src;
  logic            io_claim_valid;
  logic [IDW-1:0]  io_claim_id;
  logic            io_complete_valid;
  logic [IDW-1:0]  io_complete_id;
  logic [NSRC-1:0] io_ip;
  logic [NSRC-1:0] io_inflight;
  logic [NSRC-1:0] io_drop;

  int checks = 0;
  int errors = 0;

  // Model: 0 = idle, 1 = pending, 2 = in flight; cnt is the queued-edge count.
  int              m_st  [NSRC];
  int              m_cnt [NSRC];
  bit              m_prev[NSRC];
  logic [NSRC-1:0] exp_ip, exp_inf, exp_drop;

  plic_gateway_bank #(.NSRC(NSRC), .IDW(IDW), .EDGE_MASK(EMASK)) dut (
    .clock             (clock),
    .reset             (reset),
    .io_src            (io_src),
    .io_claim_valid    (io_claim_valid),
    .io_claim_id       (io_claim_id),
    .io_complete_valid (io_complete_valid),
    .io_complete_id    (io_complete_id),
    .io_ip             (io_ip),
    .io_inflight       (io_inflight),
    .io_drop           (io_drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_step(input logic r, input logic [NSRC-1:0] s, input logic cv,
                            input int ci, input logic pv, input int pi);
    for (int i = 0; i < NSRC; i++) begin
      int tok;
      bit is_edge;
      bit req;
      int old;
      if (r) begin
        m_st[i] = 0; m_cnt[i] = 0; m_prev[i] = 0;
        exp_drop[i] = 1'b0;
      end else begin
        is_edge = EMASK[i];
        tok = m_cnt[i] + ((is_edge && s[i] && !m_prev[i]) ? 1 : 0);
        req = is_edge ? (tok > 0) : s[i];
        exp_drop[i] = is_edge && (tok == 4);
        old = m_st[i];
        if (old == 0 && req) m_st[i] = 1;
        else if (old == 1 && cv && ci == i + 1) m_st[i] = 2;
        else if (old == 2 && pv && pi == i + 1) m_st[i] = 0;
        if (is_edge) begin
          if (old == 0 && tok > 0) tok = tok - 1;
          m_cnt[i] = (tok > 3) ? 3 : tok;
        end
        m_prev[i] = s[i];
      end
      exp_ip[i]  = (m_st[i] == 1);
      exp_inf[i] = (m_st[i] == 2);
    end
  endtask

  task automatic chk(input string tag, input logic [NSRC-1:0] obs, input logic [NSRC-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then compare all outputs.
  task automatic cyc(input logic r, input logic [NSRC-1:0] s, input logic cv,
                     input int ci, input logic pv, input int pi);
    reset = r; io_src = s;
    io_claim_valid = cv;    io_claim_id    = IDW'(ci);
    io_complete_valid = pv; io_complete_id = IDW'(pi);
    @(posedge clock);
    model_step(r, s, cv, ci, pv, pi);
    #1;
    chk("model_ip", io_ip, exp_ip);
    chk("model_inflight", io_inflight, exp_inf);
    chk("model_drop", io_drop, exp_drop);
  endtask

  task automatic idle(input logic [NSRC-1:0] s);
    cyc(1'b0, s, 1'b0, 0, 1'b0, 0);
  endtask

  initial begin
    reset = 1'b1; io_src = '0;
    io_claim_valid = 1'b0; io_claim_id = '0;
    io_complete_valid = 1'b0; io_complete_id = '0;

    cyc(1'b1, 4'b0000, 1'b0, 0, 1'b0, 0);
    cyc(1'b1, 4'b0000, 1'b0, 0, 1'b0, 0);
    chk("reset_ip", io_ip, 4'b0000);
    chk("reset_inflight", io_inflight, 4'b0000);
    for (int k = 0; k < 10; k++) idle(4'b0000);
    chk("quiet_ip", io_ip, 4'b0000);
    chk("quiet_drop", io_drop, 4'b0000);

    // Level source 0: pend, claim, complete with src still high, re-arm.
    idle(4'b0001);
    chk("lvl_pend", io_ip, 4'b0001);
    idle(4'b0001);
    idle(4'b0001);
    cyc(1'b0, 4'b0001, 1'b1, 1, 1'b0, 0);
    chk("lvl_claim_ip", io_ip, 4'b0000);
    chk("lvl_claim_inf", io_inflight, 4'b0001);
    idle(4'b0001);
    idle(4'b0001);
    cyc(1'b0, 4'b0001, 1'b0, 0, 1'b1, 1);
    chk("lvl_cmpl_inf", io_inflight, 4'b0000);
    chk("lvl_cmpl_gap", io_ip, 4'b0000);
    idle(4'b0001);
    chk("lvl_rearm", io_ip, 4'b0001);
    cyc(1'b0, 4'b0000, 1'b1, 1, 1'b0, 0);
    cyc(1'b0, 4'b0000, 1'b0, 0, 1'b1, 1);
    idle(4'b0000);
    chk("lvl_clean", io_ip, 4'b0000);

    // Edge source 1: four edges while in flight saturate the counter and drop one.
    idle(4'b0010);
    chk("edge_pend", io_ip, 4'b0010);
    idle(4'b0000);
    cyc(1'b0, 4'b0000, 1'b1, 2, 1'b0, 0);
    chk("edge_claim", io_inflight, 4'b0010);
    for (int k = 0; k < 4; k++) begin
      idle(4'b0010);
      chk("edge_drop", io_drop, (k == 3) ? 4'b0010 : 4'b0000);
      idle(4'b0000);
    end
    chk("edge_drop_once", io_drop, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 4'b0000, 1'b0, 0, 1'b1, 2);
      idle(4'b0000);
      chk("edge_requeue", io_ip, 4'b0010);
      cyc(1'b0, 4'b0000, 1'b1, 2, 1'b0, 0);
    end
    cyc(1'b0, 4'b0000, 1'b0, 0, 1'b1, 2);
    idle(4'b0000);
    idle(4'b0000);
    chk("edge_drained", io_ip, 4'b0000);

    // Ignored IDs and wrong-state completes; then same-ID claim+complete.
    idle(4'b0010);
    idle(4'b0000);
    cyc(1'b0, 4'b0000, 1'b1, 0, 1'b0, 0);
    cyc(1'b0, 4'b0000, 1'b1, 7, 1'b0, 0);
    cyc(1'b0, 4'b0000, 1'b0, 0, 1'b1, 2);
    chk("ign_ip", io_ip, 4'b0010);
    chk("ign_inf", io_inflight, 4'b0000);
    cyc(1'b0, 4'b0000, 1'b1, 2, 1'b1, 2);
    chk("same_id_inf", io_inflight, 4'b0010);
    chk("same_id_ip", io_ip, 4'b0000);
    cyc(1'b0, 4'b0000, 1'b0, 0, 1'b1, 2);

    // Different-ID claim and complete in one cycle.
    idle(4'b0101);
    idle(4'b0000);
    chk("dual_pend", io_ip, 4'b0101);
    cyc(1'b0, 4'b0000, 1'b1, 3, 1'b0, 0);
    chk("dual_claim3", io_inflight, 4'b0100);
    cyc(1'b0, 4'b0000, 1'b1, 1, 1'b1, 3);
    chk("dual_inf", io_inflight, 4'b0001);
    chk("dual_ip", io_ip, 4'b0000);
    cyc(1'b0, 4'b0000, 1'b0, 0, 1'b1, 1);

    // Reset while in flight; a high edge source right after reset counts as a rise.
    idle(4'b0010);
    cyc(1'b0, 4'b0010, 1'b1, 2, 1'b0, 0);
    chk("rst_pre_inf", io_inflight, 4'b0010);
    cyc(1'b1, 4'b0010, 1'b1, 2, 1'b1, 2);
    chk("rst_mid_ip", io_ip, 4'b0000);
    chk("rst_mid_inf", io_inflight, 4'b0000);
    chk("rst_mid_drop", io_drop, 4'b0000);
    idle(4'b0010);
    chk("rst_first_rise", io_ip, 4'b0010);
    cyc(1'b1, 4'b0000, 1'b0, 0, 1'b0, 0);

    // Random traffic against the model.
    for (int k = 0; k < 800; k++) begin
      cyc(($urandom_range(0, 63) == 0), NSRC'($urandom),
          $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
          $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
